// File: rtl/adder_share_pkg.sv
// Shared types and constants for the adder-sharing scheduler.
package adder_share_pkg;

    localparam int ADDER_W  = 32;
    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [ADDER_W-1:0]  sum;
        logic                cout;
    } adder_rsp_t;

    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/adder_koggestone_32u.sv
// 32-bit unsigned Kogge-Stone prefix adder (combinational core, registered by the caller).
module adder_koggestone_32u (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);

    logic [31:0] p0, g, p;

    always_comb begin
        p0 = a_i ^ b_i;
        g  = a_i & b_i;
        p  = p0;
        // Five doubling levels; low bits outside the span keep their group terms.
        for (int l = 0; l < 5; l++) begin
            g = g | (p & (g << (1 << l)));
            p = p & ((p << (1 << l)) | ((32'd1 << (1 << l)) - 32'd1));
        end
        sum_o  = p0 ^ {g[30:0], 1'b0};
        cout_o = g[31];
    end

endmodule

// File: rtl/adder_share_rr_arb.sv
// Request arbiter: round-robin by default, fixed lowest-index priority when
// ADDER_SHARE_FIXED_PRIO_EN is defined.
module adder_share_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o
);

`ifdef ADDER_SHARE_FIXED_PRIO_EN
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (en_i && req_i[i]) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
                idx_o      = IDW'(i);
            end
        end
    end
`else
    logic [IDW-1:0] ptr_q, ptr_d;
    int             best_d, d;

    // The winner is the valid requester at the smallest distance above ptr_q.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        best_d  = NREQ;
        d       = 0;
        for (int i = 0; i < NREQ; i++) begin
            d = (i - int'(ptr_q) + NREQ) % NREQ;
            if (en_i && req_i[i] && d < best_d) begin
                best_d     = d;
                grant_o    = '0;
                grant_o[i] = 1'b1;
                idx_o      = IDW'(i);
            end
        end
        ptr_d = (|grant_o) ? IDW'((int'(idx_o) + 1) % NREQ) : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`endif

endmodule

// File: rtl/adder_share_sched.sv
// Shares one prefix adder among NREQ requesters with credit-based issue and an
// in-order FWFT response FIFO. Build option: ADDER_SHARE_FIXED_PRIO_EN.
module adder_share_sched
    import adder_share_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int RSP_DEPTH = 4,
    localparam int IDW      = id_width(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*ADDER_W-1:0] req_a,
    input  logic [NREQ*ADDER_W-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [ADDER_W-1:0]      rsp_sum,
    output logic                    rsp_cout,
    output logic                    busy
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic               issue_ok, accept;
    int                 inflight;
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     gidx;
    logic [ADDER_W-1:0] op_a, op_b;

    logic               s1_v_q, s2_v_q;
    logic [ADDER_W-1:0] s1_a_q, s1_b_q;
    logic [IDW-1:0]     s1_id_q;
    adder_rsp_t         s2_q;
    logic [ADDER_W-1:0] add_sum;
    logic               add_cout;

    adder_rsp_t         mem_q [RSP_DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic               push, pop;
    adder_rsp_t         head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == RSP_DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    // Credits cover every op already accepted and not yet popped.
    always_comb begin
        inflight = int'(count_q) + int'(s1_v_q) + int'(s2_v_q);
        issue_ok = inflight < RSP_DEPTH;
    end

    adder_share_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_valid),
        .en_i    (issue_ok && !rst),
        .grant_o (grant),
        .idx_o   (gidx)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                op_a = req_a[i*ADDER_W +: ADDER_W];
                op_b = req_b[i*ADDER_W +: ADDER_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
        end else begin
            s1_v_q <= accept;
            s2_v_q <= s1_v_q;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a_q  <= op_a;
            s1_b_q  <= op_b;
            s1_id_q <= gidx;
        end
        s2_q.id   <= ID_MAX_W'(s1_id_q);
        s2_q.sum  <= add_sum;
        s2_q.cout <= add_cout;
    end

    adder_koggestone_32u u_add (
        .a_i    (s1_a_q),
        .b_i    (s1_b_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    assign push = s2_v_q;
    assign pop  = rsp_valid && rsp_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s2_q;
    end

    // Payload is zeroed while empty so stale storage never shows after reset.
    assign head      = mem_q[rd_ptr_q];
    assign rsp_valid = (count_q != '0);
    assign rsp_id    = rsp_valid ? IDW'(head.id) : '0;
    assign rsp_sum   = rsp_valid ? head.sum : '0;
    assign rsp_cout  = rsp_valid ? head.cout : 1'b0;
    assign busy      = s1_v_q || s2_v_q || rsp_valid;

endmodule

// File: tb/tb_adder_share_sched.sv
// Bench for adder_share_sched: queue-based reference model plus directed scenarios.
module tb_adder_share_sched;

    localparam int NREQ  = 4;
    localparam int DEPTH = 4;
    localparam int IDW   = $clog2(NREQ);

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*32-1:0] req_a, req_b;
    logic              rsp_valid, rsp_ready, rsp_cout, busy;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_sum;

    adder_share_sched #(.NREQ(NREQ), .RSP_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: outstanding ops in accept order with the cycle each becomes visible.
    typedef struct packed {
        int          id;
        logic [32:0] res;
        int          rdy;
    } exp_t;

    exp_t            q[$];
    int              m_ptr = 0;
    int              mj, acc_i;
    logic            found_m, exp_rv;
    logic [NREQ-1:0] exp_rdy;

    // Observation logs used by the directed scenarios.
    int          gl_idx[$], gl_cyc[$];
    int          rl_id[$], rl_cyc[$];
    logic [32:0] rl_res[$];

    always @(negedge clk) begin
        if (chk_en) begin
            exp_rdy = '0;
            found_m = 1'b0;
            acc_i   = 0;
            if (!rst && q.size() < DEPTH) begin
                for (int k = 0; k < NREQ; k++) begin
                    mj = (m_ptr + k) % NREQ;
                    if (!found_m && req_valid[mj]) begin
                        exp_rdy[mj] = 1'b1;
                        found_m     = 1'b1;
                        acc_i       = mj;
                    end
                end
            end
            exp_rv = (q.size() > 0) && (q[0].rdy <= cyc);
            chk("m_req_ready", req_ready, exp_rdy);
            chk("m_rsp_valid", rsp_valid, exp_rv);
            chk("m_busy", busy, q.size() > 0);
            if (exp_rv) begin
                chk("m_rsp_id", rsp_id, q[0].id);
                chk("m_rsp_res", {rsp_cout, rsp_sum}, q[0].res);
            end

            if (!rst) begin
                for (int i = 0; i < NREQ; i++)
                    if (req_ready[i] && req_valid[i]) begin
                        gl_idx.push_back(i);
                        gl_cyc.push_back(cyc);
                    end
                if (rsp_valid && rsp_ready) begin
                    rl_id.push_back(int'(rsp_id));
                    rl_res.push_back({rsp_cout, rsp_sum});
                    rl_cyc.push_back(cyc);
                end
            end

            if (rst) begin
                q.delete();
                m_ptr = 0;
            end else begin
                if (exp_rv && rsp_ready) void'(q.pop_front());
                if (found_m) begin
                    q.push_back('{id: acc_i,
                                  res: {1'b0, req_a[acc_i*32 +: 32]} + {1'b0, req_b[acc_i*32 +: 32]},
                                  rdy: cyc + 3});
`ifndef ADDER_SHARE_FIXED_PRIO_EN
                    m_ptr = (acc_i + 1) % NREQ;
`endif
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        gl_idx.delete(); gl_cyc.delete();
        rl_id.delete(); rl_res.delete(); rl_cyc.delete();
    endtask

    int   lat;
    logic found;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) step();
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_cout", rsp_cout, 0);
        chk("rst_busy", busy, 0);
        step();
        rst = 1'b0;

        // Single request with carry out
        rsp_ready     = 1'b1;
        req_a[31:0]   = 32'hFFFF_FFFF;
        req_b[31:0]   = 32'h0000_0001;
        req_valid     = 4'b0001;
        @(negedge clk);
        chk("t1_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        lat   = 0;
        found = 1'b0;
        for (int n = 1; n <= 8 && !found; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                found = 1'b1;
                lat   = n;
                chk("t1_id", rsp_id, 0);
                chk("t1_sum", rsp_sum, 32'h0000_0000);
                chk("t1_cout", rsp_cout, 1);
            end
        end
        chk("t1_latency", lat, 3);
        step();
        @(negedge clk);
        chk("t1_busy_after", busy, 0);
        step();

        // All requesters contending
        do_reset();
        clear_logs();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = i;
            req_b[i*32 +: 32] = 32'h10;
        end
        req_valid = 4'hF;
        repeat (4) step();
        req_valid = '0;
        repeat (8) step();
        chk("t2_ngrant", gl_idx.size(), 4);
        chk("t2_nrsp", rl_id.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < gl_idx.size()) chk("t2_grant_order", gl_idx[k], k);
            if (k > 0 && k < gl_cyc.size()) chk("t2_grant_b2b", gl_cyc[k] - gl_cyc[k-1], 1);
            if (k < rl_id.size()) begin
                chk("t2_rsp_id", rl_id[k], k);
                chk("t2_rsp_res", rl_res[k], 33'h10 + k);
            end
            if (k > 0 && k < rl_cyc.size()) chk("t2_rsp_b2b", rl_cyc[k] - rl_cyc[k-1], 1);
        end

        // Pointer wrap: last grant was 3, now only 1 and 3 valid
        clear_logs();
        req_a[1*32 +: 32] = 32'd5;
        req_b[1*32 +: 32] = 32'd7;
        req_a[3*32 +: 32] = 32'hFFFF_FFFF;
        req_b[3*32 +: 32] = 32'hFFFF_FFFF;
        req_valid = 4'b1010;
        repeat (2) step();
        req_valid = '0;
        repeat (6) step();
        chk("t3_ngrant", gl_idx.size(), 2);
        if (gl_idx.size() >= 2) begin
            chk("t3_grant0", gl_idx[0], 1);
            chk("t3_grant1", gl_idx[1], 3);
        end
        if (rl_res.size() >= 2) begin
            chk("t3_res0", rl_res[0], 33'h0_0000_000C);
            chk("t3_res1", rl_res[1], 33'h1_FFFF_FFFE);
        end

        // Backpressure
        clear_logs();
        rsp_ready         = 1'b0;
        req_b[2*32 +: 32] = 32'd0;
        req_valid         = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            req_a[2*32 +: 32] = 32'h1000 + k;
            step();
        end
        @(negedge clk);
        chk("t4_ready_low", req_ready, 0);
        chk("t4_naccept", gl_idx.size(), 4);
        step();
        rsp_ready = 1'b1;
        for (int k = 10; k < 14; k++) begin
            req_a[2*32 +: 32] = 32'h1000 + k;
            step();
        end
        req_valid = '0;
        repeat (10) step();
        chk("t4_resumed", gl_idx.size() >= 5, 1);
        if (gl_cyc.size() >= 5 && rl_cyc.size() >= 1)
            chk("t4_resume_gap", gl_cyc[4] - rl_cyc[0], 1);
        for (int k = 0; k < 4; k++) begin
            if (k < rl_id.size()) begin
                chk("t4_rsp_id", rl_id[k], 2);
                chk("t4_rsp_res", rl_res[k], 33'h1000 + k);
            end
        end

        // Reset with two ops in flight and one queued
        clear_logs();
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) req_a[i*32 +: 32] = 32'h200 + i;
        req_valid = 4'b1110;
        repeat (3) step();
        chk("t5_naccept", gl_idx.size(), 3);
        clear_logs();
        rst       = 1'b1;
        req_valid = 4'hF;
        step();
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_busy", busy, 0);
        repeat (6) step();
        chk("t5_no_stale", rl_id.size(), 0);
        chk("t5_no_grant", gl_idx.size(), 0);
        req_valid = 4'hF;
        @(negedge clk);
        chk("t5_first_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        repeat (6) step();

`ifdef ADDER_SHARE_FIXED_PRIO_EN
        // Fixed priority starves requester 3
        do_reset();
        clear_logs();
        req_valid = 4'b1010;
        repeat (6) step();
        req_valid = '0;
        repeat (6) step();
        chk("t6_ngrant", gl_idx.size(), 6);
        foreach (gl_idx[k]) chk("t6_grant_is_1", gl_idx[k], 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
